ahb_latency_ram: RTL

- AHB-Lite subordinate that sits between the uncore AHB decoder and a single-port synchronous SRAM macro.
- Adds a programmable number of wait states to every data phase, so bus masters (IFU/LSU bus FSMs) can be stress-tested against slow memory.
- Provides the uncore RAM region. Its LATENCY parameter is driven from the RAM_LATENCY configuration field.

---
 rtl/ahb_latency_ram.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ahb_latency_ram.sv
// rtl/ahb_latency_ram.sv - AHB-Lite SRAM subordinate with programmable data-phase wait states
// Optional feature macro AHB_LATENCY_RAM_BURST_EN: incrementing SEQ beats take zero wait states.
module ahb_latency_ram #(
    parameter int AHBW      = 64,
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 0
) (
    input  logic                                HCLK,
    input  logic                                HRESETn,
    input  logic                                HSELRam,
    input  logic [ADDR_BITS+$clog2(AHBW/8)-1:0] HADDR,
    input  logic [1:0]                          HTRANS,
    input  logic                                HWRITE,
    input  logic [AHBW-1:0]                     HWDATA,
    input  logic [AHBW/8-1:0]                   HWSTRB,
    input  logic                                HREADY,
    output logic [AHBW-1:0]                     HREADRam,
    output logic                                HREADYRam,
    output logic                                HRESPRam,
    output logic                                RamCE,
    output logic                                RamWE,
    output logic [ADDR_BITS-1:0]                RamAddr,
    output logic [AHBW/8-1:0]                   RamByteMask,
    output logic [AHBW-1:0]                     RamWriteData,
    input  logic [AHBW-1:0]                     RamReadData
);
    localparam int BW   = AHBW / 8;
    localparam int OFFS = $clog2(BW);
    localparam int HAW  = ADDR_BITS + OFFS;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_LAST = 2'd2,
        S_COLL = 2'd3
    } state_t;

    state_t                 state, state_d;
    logic [3:0]             cnt, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   write_q;
    logic                   take;
    logic                   burst_fast;
    logic                   fast;
    logic                   collide;
    logic                   issue_now;

    // A transfer can only be taken while this slave has no wait pending.
    assign take = HSELRam && HREADY && HTRANS[1] && (state == S_IDLE || state == S_LAST);

`ifdef AHB_LATENCY_RAM_BURST_EN
    logic [HAW-1:0] prev_addr;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            prev_addr <= '0;
        end else if (take) begin
            prev_addr <= HADDR;
        end
    end

    assign burst_fast = (HTRANS == 2'b11) && (HADDR == prev_addr + HAW'(BW));
`else
    logic unused_burst;

    assign burst_fast   = 1'b0;
    assign unused_burst = ^{HTRANS[0], HADDR[OFFS-1:0]};
`endif

    assign fast = (LATENCY == 0) || burst_fast;

    // A zero-wait read cannot use the SRAM while a write owns it in LAST.
    assign collide   = take && fast && !HWRITE && (state == S_LAST) && write_q;
    assign issue_now = take && fast && !HWRITE && !collide;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (take) begin
                addr_q  <= HADDR[HAW-1:OFFS];
                write_q <= HWRITE;
            end
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE, S_LAST: begin
                if (take) begin
                    if (collide) begin
                        state_d = S_COLL;
                    end else if (fast) begin
                        state_d = S_LAST;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_d = S_LAST;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            S_COLL: begin
                state_d = S_LAST;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        HREADYRam    = (state == S_IDLE) || (state == S_LAST);
        HRESPRam     = 1'b0;
        HREADRam     = '0;
        RamCE        = 1'b0;
        RamWE        = 1'b0;
        RamAddr      = addr_q;
        RamByteMask  = '1;
        RamWriteData = HWDATA;

        if (state == S_LAST && !write_q) begin
            HREADRam = RamReadData;
        end

        if (state == S_LAST && write_q) begin
            RamCE       = 1'b1;
            RamWE       = 1'b1;
            RamByteMask = HWSTRB;
        end else if (state == S_WAIT && cnt == 4'd0 && !write_q) begin
            RamCE = 1'b1;
        end else if (state == S_COLL) begin
            RamCE = 1'b1;
        end

        // Zero-wait reads issue in their own address phase.
        if (issue_now) begin
            RamCE   = 1'b1;
            RamAddr = HADDR[HAW-1:OFFS];
        end
    end
endmodule
